// File: rtl/yuv_conv_arbiter_pkg.sv
// Shared definitions for the two-channel RGB->YUV arbiter.
// Holds the FSM encoding, BT.601 coefficients and pipeline bundles.
package yuv_conv_arbiter_pkg;

    localparam int PIX_W      = 24;
    localparam int CONV_SHIFT = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
    } arb_state_e;

    localparam logic signed [15:0] C_YR = 16'sd10;
    localparam logic signed [15:0] C_YG = 16'sd19;
    localparam logic signed [15:0] C_YB = 16'sd4;
    localparam logic signed [15:0] C_UR = -16'sd5;
    localparam logic signed [15:0] C_UG = -16'sd9;
    localparam logic signed [15:0] C_UB = 16'sd14;
    localparam logic signed [15:0] C_VR = 16'sd20;
    localparam logic signed [15:0] C_VG = -16'sd16;
    localparam logic signed [15:0] C_VB = -16'sd3;

    typedef struct packed {
        logic [PIX_W-1:0] rgb;
        logic             chan;
    } stage_a_t;

    typedef struct packed {
        logic [PIX_W-1:0] yuv;
        logic             chan;
    } stage_b_t;

    function automatic logic [7:0] clamp8(input logic signed [15:0] x);
        if (x < 16'sd0) begin
            clamp8 = 8'd0;
        end else if (x > 16'sd255) begin
            clamp8 = 8'hFF;
        end else begin
            clamp8 = x[7:0];
        end
    endfunction

endpackage

// File: rtl/yuv_conv_arbiter_rgb2yuv.sv
// Combinational BT.601 RGB->YUV with 5-bit fixed-point coefficients.
// Each component is computed in signed 16 bits and clamped to 0..255.
module yuv_conv_arbiter_rgb2yuv
    import yuv_conv_arbiter_pkg::*;
(
    input  logic [PIX_W-1:0] rgb_i,
    output logic [PIX_W-1:0] yuv_o
);

    logic signed [15:0] r;
    logic signed [15:0] g;
    logic signed [15:0] b;
    logic signed [15:0] y_s;
    logic signed [15:0] u_s;
    logic signed [15:0] v_s;

    assign r = {8'd0, rgb_i[23:16]};
    assign g = {8'd0, rgb_i[15:8]};
    assign b = {8'd0, rgb_i[7:0]};

    assign y_s = (C_YR * r + C_YG * g + C_YB * b) >>> CONV_SHIFT;
    assign u_s = (C_UR * r + C_UG * g + C_UB * b) >>> CONV_SHIFT;
    assign v_s = (C_VR * r + C_VG * g + C_VB * b) >>> CONV_SHIFT;

    assign yuv_o = {clamp8(y_s), clamp8(u_s), clamp8(v_s)};

endmodule

// File: rtl/yuv_conv_arbiter.sv
// Two-channel burst arbiter feeding a 2-stage RGB->YUV pipeline.
// Fair round-robin with a per-grant burst limit and full backpressure.
module yuv_conv_arbiter
    import yuv_conv_arbiter_pkg::*;
#(
    parameter int BURST_LEN = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s0_valid,
    output logic             s0_ready,
    input  logic [PIX_W-1:0] s0_rgb,
    input  logic             s1_valid,
    output logic             s1_ready,
    input  logic [PIX_W-1:0] s1_rgb,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [PIX_W-1:0] m_yuv,
    output logic             m_chan,
    output logic [15:0]      pix_cnt0,
    output logic [15:0]      pix_cnt1,
    output logic             busy
);

    localparam logic [8:0] BURST_W = 9'(BURST_LEN);

    arb_state_e state_q, state_d;
    logic [8:0] beat_q, beat_d;
    logic       last_q, last_d;
    logic       hold_q, hold_d;

    stage_a_t   a_q;
    logic       a_vld_q;
    stage_b_t   b_q;
    logic       b_vld_q;
    logic [15:0] cnt0_q;
    logic [15:0] cnt1_q;

    logic             advance;
    logic             a_space;
    logic             acc0;
    logic             acc1;
    logic             acc;
    logic             cur_v;
    logic             oth_v;
    arb_state_e       oth_st;
    logic [PIX_W-1:0] conv_yuv;

    assign advance = !b_vld_q || m_ready;
    assign a_space = !a_vld_q || advance;

    assign s0_ready = (state_q == ST_GRANT0) && !hold_q && a_space;
    assign s1_ready = (state_q == ST_GRANT1) && !hold_q && a_space;

    assign acc0 = s0_valid && s0_ready;
    assign acc1 = s1_valid && s1_ready;
    assign acc  = acc0 || acc1;

    assign cur_v  = (state_q == ST_GRANT1) ? s1_valid : s0_valid;
    assign oth_v  = (state_q == ST_GRANT1) ? s0_valid : s1_valid;
    assign oth_st = (state_q == ST_GRANT1) ? ST_GRANT0 : ST_GRANT1;

    // Grant decision, burst counting and one-cycle bubble on burst switch.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        last_d  = last_q;
        hold_d  = 1'b0;
        if (acc) begin
            last_d = acc1;
        end
        unique case (state_q)
            ST_IDLE: begin
                beat_d = '0;
                if (s0_valid && (!s1_valid || last_q)) begin
                    state_d = ST_GRANT0;
                end else if (s1_valid) begin
                    state_d = ST_GRANT1;
                end
            end
            ST_GRANT0, ST_GRANT1: begin
                if (!cur_v) begin
                    beat_d  = '0;
                    state_d = oth_v ? oth_st : ST_IDLE;
                end else if (acc) begin
                    if (beat_q + 9'd1 == BURST_W) begin
                        beat_d = '0;
                        if (oth_v) begin
                            state_d = oth_st;
                            hold_d  = 1'b1;
                        end
                    end else begin
                        beat_d = beat_q + 9'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                beat_d  = '0;
            end
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            last_q  <= 1'b1;
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

    // Stage A captures the accepted pixel and its source channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_vld_q <= 1'b0;
            a_q     <= '0;
        end else if (a_space) begin
            a_vld_q <= acc;
            if (acc) begin
                a_q <= '{rgb: (acc1 ? s1_rgb : s0_rgb), chan: acc1};
            end
        end
    end

    yuv_conv_arbiter_rgb2yuv u_conv (
        .rgb_i (a_q.rgb),
        .yuv_o (conv_yuv)
    );

    // Stage B holds the converted pixel until downstream accepts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_vld_q <= 1'b0;
            b_q     <= '0;
        end else if (advance) begin
            b_vld_q <= a_vld_q;
            if (a_vld_q) begin
                b_q <= '{yuv: conv_yuv, chan: a_q.chan};
            end
        end
    end

    // Per-channel accepted-pixel counters, free-running wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_q + {15'd0, acc0};
            cnt1_q <= cnt1_q + {15'd0, acc1};
        end
    end

    assign m_valid  = b_vld_q;
    assign m_yuv    = b_q.yuv;
    assign m_chan   = b_q.chan;
    assign pix_cnt0 = cnt0_q;
    assign pix_cnt1 = cnt1_q;
    assign busy     = (state_q != ST_IDLE) || a_vld_q || b_vld_q;

endmodule

// File: doc/yuv_conv_arbiter.md
YUV_CONV_ARBITER -- requirements
Module: yuv_conv_arbiter

Interface
REQ-001 Parameter BURST_LEN, default 16: maximum consecutive pixels granted to one channel while the other channel is waiting; legal range 1..256.
REQ-002 clk  input  1  single clock; all state is updated on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 s0_valid / s1_valid  input  1  channel 0/1 pixel valid.
REQ-005 s0_ready / s1_ready  output  1  channel 0/1 pixel accepted when valid and ready are both high.
REQ-006 s0_rgb / s1_rgb  input  24  channel 0/1 pixel, packed as {R,G,B}, 8 bits each.
REQ-007 m_valid  output  1  converted pixel valid.
REQ-008 m_ready  input  1  downstream accept.
REQ-009 m_yuv  output  24  converted pixel, packed as {Y,U,V}, 8 bits each.
REQ-010 m_chan  output  1  source channel of m_yuv.
REQ-011 pix_cnt0 / pix_cnt1  output  16  accepted-pixel count per channel; wraps 0xFFFF->0x0000.
REQ-012 busy  output  1  high when the FSM is not IDLE or either pipeline stage holds data.

Function
REQ-013 The FSM states shall be IDLE, GRANT0 and GRANT1; at most one sN_ready may be high in any cycle, and only in the matching GRANT state.
REQ-014 From IDLE, the FSM shall move to the GRANT state of the channel with valid high; if both are valid, it shall grant the channel not served last (last_served resets to 1, so channel 0 wins first).
REQ-015 In GRANTn, the FSM shall keep a beat counter and increment it on each accepted beat.
REQ-016 When the beat counter reaches BURST_LEN on an accepted beat and the other channel is valid, the FSM shall switch to the other GRANT state and clear the counter.
REQ-017 When the beat counter reaches BURST_LEN on an accepted beat and the other channel is not valid, the FSM shall stay in GRANTn and clear the counter.
REQ-018 When sn_valid is low in GRANTn, the FSM shall go to the other GRANT state if that channel is valid, and to IDLE otherwise; the counter shall clear.
REQ-019 A grant change shall take effect the cycle after the decision; no pixel is accepted in the switching cycle.
REQ-020 Pipeline stage A shall register {rgb, chan} on accept; stage B shall register {rgb2yuv(A.rgb), A.chan} and drives m_yuv/m_chan/m_valid.
REQ-021 Latency shall be 2 cycles from accept to m_valid.
REQ-022 Throughput shall be 1 pixel per cycle while m_ready is held high.
REQ-023 Stage B shall load when it is empty or m_ready is high; stage A shall advance under the same condition.
REQ-024 sN_ready shall be high only when granted and stage A is empty or advancing; it may depend combinationally on m_ready.
REQ-025 While m_valid is high and m_ready is low, m_yuv, m_chan and m_valid shall hold stable.
REQ-026 Conversion shall follow BT.601 with 5-bit fixed point.
REQ-027 Y = (10R+19G+4B)>>>5; U = (-5R-9G+14B)>>>5; V = (20R-16G-3B)>>>5.
REQ-028 Conversion arithmetic shall be signed 16-bit, and each component shall clamp to 0..255.
REQ-029 pix_cntN shall increment by 1 per accepted channel-N beat.

Reset
REQ-030 While rst_n is low, all outputs shall be 0: s0_ready, s1_ready, m_valid, m_yuv, m_chan, pix_cnt0, pix_cnt1 and busy.
REQ-031 While rst_n is low, the FSM shall be IDLE, the beat counter 0, last_served 1, and stages A and B empty.
REQ-032 Reset asserted mid-burst or mid-transfer shall discard in-flight pixels without emitting them.
REQ-033 After reset deassertion, the first accept shall occur no earlier than the second rising edge.

Structure
REQ-034 A shared package shall hold the FSM state encoding, the coefficient constants (10, 19, 4, -5, -9, 14, 20, -16, -3), the shift of 5, and the pixel width of 24.
REQ-035 The conversion shall be a single instance of the existing combinational rgb2yuv block, placed between stages A and B.

Verification
REQ-036 Black and white: s0_rgb=0x000000, then 0xFFFFFF, with m_ready=1 -> m_yuv=0x000000 then 0xFF0007 (Y clamped), m_chan=0, each 2 cycles after accept.
REQ-037 Fairness: both channels always valid, BURST_LEN=4 -> accepted sequence is ch0 x4, one bubble, ch1 x4, one bubble, repeating; pix_cnt0 equals pix_cnt1 after 8k accepts.
REQ-038 Backpressure: m_ready=0 for 5 cycles during streaming -> m_valid held high, m_yuv stable, at most 2 pixels buffered, no loss or duplication, and order preserved after release.
REQ-039 Single channel: only s1_valid is high, BURST_LEN=2 -> FSM stays in GRANT1 and throughput is 1 pixel/cycle.
REQ-040 Idle: both valids drop -> FSM enters IDLE, and busy falls once stage B drains.
REQ-041 Reset: rst_n pulsed low mid-burst with the pipeline full -> m_valid=0 immediately, counters 0, and the next accept goes to channel 0.
